ula_acc: RTL and testbench
==========================

Name: ula_acc

Overview:
- Sequential result stage directly downstream of the 16-bit ULA (add/mult selected by op bit h).
- Consumes ULA results with a valid/ready handshake and accumulates a batch of N results into a wider sum.
- Counts how many results in the batch came from multiplication.
- Presents the batch sum, mult count and overflow flag to the next stage with a valid/ready handshake.

Parameters:
- DATA_W, 16, width of an incoming ULA result.
- ACC_W, 24, accumulator width; must be >= DATA_W.
- N, 4, results per batch; must be >= 1.
- CNT_W, $clog2(N+1), width of the batch counter and mult counter. Derived; not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- in_valid  input  1  ULA result valid.
- in_ready  output  1  stage can accept a result this cycle.
- in_data  input  DATA_W  ULA result s.
- in_op  input  1  ULA op bit h of that result: 0=soma, 1=mult.
- clr  input  1  synchronous batch abort.
- out_valid  output  1  batch result valid.
- out_ready  input  1  downstream accepts the batch.
- out_sum  output  ACC_W  batch sum.
- out_nmult  output  CNT_W  number of mult results in the batch.
- out_ovf  output  1  sticky overflow seen during the batch.

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low. All registers update on the clk rising edge only.
- Reset (rst_n=0 at an edge):
  - state=IDLE.
  - acc=0, cnt=0, nmult=0, ovf=0.
  - out_valid=0, in_ready=1.
- Accept rule: a result is taken on a cycle with in_valid=1 and in_ready=1. in_data is zero-extended to ACC_W.
- States:
  - IDLE: in_ready=1, out_valid=0. On accept: acc=in_data, cnt=1, nmult=in_op, ovf=0. Next state is HOLD if N==1, else ACC.
  - ACC: in_ready=1, out_valid=0. On accept: acc=acc+in_data, cnt=cnt+1, nmult=nmult+in_op. When the accept makes cnt==N, next state is HOLD. No accept means no state change.
  - HOLD: in_ready=0, out_valid=1. out_sum, out_nmult and out_ovf are stable while out_valid=1. On out_ready=1: next state is IDLE and acc, cnt, nmult and ovf are cleared.
- Latency: out_valid rises on the cycle after the N-th accept edge. Accept rate is 1 result/cycle outside HOLD.
- Outputs are registered. out_sum=acc, out_nmult=nmult and out_ovf=ovf in every state, so they read 0 in IDLE after reset.
- Overflow (default build): the add wraps mod 2^ACC_W. ovf is set if the add carries out of bit ACC_W-1, and stays set until the batch clears.
- clr=1:
  - Forces IDLE and clears acc, cnt, nmult and ovf.
  - Overrides any simultaneous accept or out_ready.
  - In HOLD the batch is discarded and out_valid=0 on the next cycle.
- Reset mid-batch behaves identically to clr. rst_n has priority over clr.
- in_valid held while in HOLD: not accepted. Upstream holds in_data and in_op stable until in_ready=1.
- in_data and in_op are ignored when in_valid=0.

Optional Feature:
- Macro ULA_ACC_SAT_EN.
- Defined: the add saturates. If acc+in_data exceeds 2^ACC_W-1, acc=2^ACC_W-1 and ovf=1. Further adds stay clamped.
- Undefined: wrap-around per the default build, with ovf still flagged.

Decomposition:
- Shared package ula_pkg holds:
  - the state enum {IDLE, ACC, HOLD} as 2-bit encoding 00/01/10;
  - default DATA_W and ACC_W constants, reused by ula and ula_acc;
  - op-bit encodings OP_SOMA=0 and OP_MULT=1.
- One natural sub-module: ula_acc_add.
  - Combinational ACC_W adder taking acc and the zero-extended in_data.
  - Produces the next sum and a carry/overflow bit.
  - Saturation sits inside it under ULA_ACC_SAT_EN.

Test Plan:
- Reset, then feed ULA results for e0=3,e1=2 and e0=3,e1=3 with ops soma,mult,soma,mult: in_data=5,6,6,9 with in_op=0,1,0,1 on consecutive cycles -> out_valid rises the cycle after the 4th accept, out_sum=26, out_nmult=2, out_ovf=0, in_ready=0 while held.
- Hold out_ready=0 for 5 cycles in HOLD while in_valid=1 -> outputs stable, no accept. Then out_ready=1 -> IDLE next cycle, in_ready=1, out_sum=0.
- ACC_W=16, N=2, in_data=16'hFFFF then 16'h0002 -> default build: out_sum=16'h0001, out_ovf=1. With ULA_ACC_SAT_EN: out_sum=16'hFFFF, out_ovf=1.
- Accept 2 results (7,8), then clr=1 together with in_valid=1 (data 9) -> state IDLE, acc=0, data 9 not accepted. A fresh batch of 1,1,1,1 yields out_sum=4.
- rst_n=0 for one cycle while in HOLD with out_ready=1 -> out_valid=0, all outputs 0, in_ready=1 next cycle.
- N=1: each accepted result (e.g. 6, op=1) -> HOLD the next cycle with out_sum=6 and out_nmult=1. Back-to-back batches follow with out_ready tied to 1.

Source files
------------

// File: rtl/ula_pkg.sv
// ula_pkg: shared ULA types and constants (state encoding, default widths, op bit codes).
// Rev 1.0
`default_nettype none

package ula_pkg;

   localparam int ULA_DATA_W = 16;
   localparam int ULA_ACC_W  = 24;

   localparam logic OP_SOMA = 1'b0;
   localparam logic OP_MULT = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      ACC  = 2'b01,
      HOLD = 2'b10
   } acc_state_t;

endpackage

`default_nettype wire

// File: rtl/ula_acc_add.sv
// ula_acc_add: ACC_W accumulator adder with carry-out; ULA_ACC_SAT_EN clamps instead of wrapping.
// Rev 1.0
`default_nettype none

module ula_acc_add
   import ula_pkg::*;
#(
   parameter int ACC_W = ULA_ACC_W
) (
   input  logic [ACC_W-1:0] acc,
   input  logic [ACC_W-1:0] addend,
   output logic [ACC_W-1:0] sum,
   output logic             carry
);

   logic [ACC_W:0] raw;

   assign raw   = {1'b0, acc} + {1'b0, addend};
   assign carry = raw[ACC_W];

`ifdef ULA_ACC_SAT_EN
   assign sum = carry ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
   assign sum = raw[ACC_W-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/ula_acc.sv
// ula_acc: accumulates N ULA results per batch, counts mult ops, hands off via valid/ready.
// Rev 1.0 -- optional macro ULA_ACC_SAT_EN selects a saturating sum.
`default_nettype none

module ula_acc
   import ula_pkg::*;
#(
   parameter int DATA_W = ULA_DATA_W,
   parameter int ACC_W  = ULA_ACC_W,
   parameter int N      = 4,
   parameter int CNT_W  = $clog2(N + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_op,
   input  logic              clr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_sum,
   output logic [CNT_W-1:0]  out_nmult,
   output logic              out_ovf
);

   acc_state_t       state, state_nx;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] nmult;
   logic             ovf;

   logic             take;
   logic             last;
   logic             drain;
   logic [ACC_W-1:0] sum_nx;
   logic             carry;

   // HOLD is the only state with bit 1 set, so both handshake outputs are a flop bit.
   assign out_valid = state[1];
   assign in_ready  = ~state[1];

   assign take  = in_valid && in_ready;
   assign last  = (cnt == CNT_W'(N - 1));
   assign drain = (state == HOLD) && out_ready;

   ula_acc_add #(
      .ACC_W (ACC_W)
   ) u_add (
      .acc    (acc),
      .addend (ACC_W'(in_data)),
      .sum    (sum_nx),
      .carry  (carry)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE, ACC: begin
            if (take) begin
               state_nx = last ? HOLD : ACC;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
      if (clr) begin
         state_nx = IDLE;
      end
   end

   // Every path into IDLE clears the batch registers, so an IDLE accept is acc = 0 + in_data.
   always_ff @(posedge clk) begin
      if (!rst_n || clr || drain) begin
         acc   <= '0;
         cnt   <= '0;
         nmult <= '0;
         ovf   <= 1'b0;
      end else if (take) begin
         acc   <= sum_nx;
         cnt   <= cnt + CNT_W'(1);
         nmult <= nmult + CNT_W'(in_op == OP_MULT);
         ovf   <= ovf | carry;
      end
   end

   assign out_sum   = acc;
   assign out_nmult = nmult;
   assign out_ovf   = ovf;

endmodule

`default_nettype wire

// File: tb/tb_ula_acc.sv
// tb_ula_acc: three ula_acc instances (default, ACC_W=16/N=2, N=1) against a sum-based reference model.
// Rev 1.0
`default_nettype none

module tb_ula_acc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] in_data;
   logic        in_op;
   logic        clr;
   logic        out_ready;

   logic        rdy0, vld0, ovf0;
   logic [23:0] sum0;
   logic [2:0]  nm0;
   logic        rdy1, vld1, ovf1;
   logic [15:0] sum1;
   logic [1:0]  nm1;
   logic        rdy2, vld2, ovf2;
   logic [23:0] sum2;
   logic [0:0]  nm2;

   int checks = 0;
   int errors = 0;

   longint m_sum  [3];
   int     m_cnt  [3];
   int     m_nm   [3];
   bit     m_hold [3];

   always #5 clk = ~clk;

   ula_acc u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
      .in_data(in_data), .in_op(in_op), .clr(clr), .out_valid(vld0),
      .out_ready(out_ready), .out_sum(sum0), .out_nmult(nm0), .out_ovf(ovf0)
   );

   ula_acc #(.ACC_W(16), .N(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
      .in_data(in_data), .in_op(in_op), .clr(clr), .out_valid(vld1),
      .out_ready(out_ready), .out_sum(sum1), .out_nmult(nm1), .out_ovf(ovf1)
   );

   ula_acc #(.N(1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
      .in_data(in_data), .in_op(in_op), .clr(clr), .out_valid(vld2),
      .out_ready(out_ready), .out_sum(sum2), .out_nmult(nm2), .out_ovf(ovf2)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic int n_of(input int k);
      case (k)
         0:       return 4;
         1:       return 2;
         default: return 1;
      endcase
   endfunction

   function automatic longint lim(input int k);
      int w;
      w = (k == 1) ? 16 : 24;
      return (longint'(1) << w) - 1;
   endfunction

   // The exact batch total decides everything: wrap is modulo, saturation is min(), ovf is total > max.
   function automatic longint exp_sum(input int k);
`ifdef ULA_ACC_SAT_EN
      return (m_sum[k] > lim(k)) ? lim(k) : m_sum[k];
`else
      return m_sum[k] & lim(k);
`endif
   endfunction

   task automatic model_clear(input int k);
      m_sum[k]  = 0;
      m_cnt[k]  = 0;
      m_nm[k]   = 0;
      m_hold[k] = 1'b0;
   endtask

   task automatic model_edge();
      for (int k = 0; k < 3; k++) begin
         if (!rst_n || clr) begin
            model_clear(k);
         end else if (m_hold[k]) begin
            if (out_ready) model_clear(k);
         end else if (in_valid) begin
            m_sum[k] += longint'(in_data);
            m_cnt[k]++;
            m_nm[k] += int'(in_op);
            if (m_cnt[k] == n_of(k)) m_hold[k] = 1'b1;
         end
      end
   endtask

   task automatic compare_all();
      logic [63:0] s;
      logic [63:0] nm;
      logic        v, r, o;
      for (int k = 0; k < 3; k++) begin
         case (k)
            0:       begin s = 64'(sum0); nm = 64'(nm0); v = vld0; r = rdy0; o = ovf0; end
            1:       begin s = 64'(sum1); nm = 64'(nm1); v = vld1; r = rdy1; o = ovf1; end
            default: begin s = 64'(sum2); nm = 64'(nm2); v = vld2; r = rdy2; o = ovf2; end
         endcase
         check($sformatf("u%0d.out_valid", k), 64'(v), 64'(m_hold[k]));
         check($sformatf("u%0d.in_ready", k), 64'(r), 64'(!m_hold[k]));
         check($sformatf("u%0d.out_sum", k), s, 64'(exp_sum(k)));
         check($sformatf("u%0d.out_nmult", k), nm, 64'(m_nm[k]));
         check($sformatf("u%0d.out_ovf", k), 64'(o), 64'(m_sum[k] > lim(k)));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   initial begin
      logic [15:0] d4 [4];
      logic        o4 [4];
      d4 = '{16'd5, 16'd6, 16'd6, 16'd9};
      o4 = '{1'b0, 1'b1, 1'b0, 1'b1};

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_op = 1'b0; clr = 1'b0; out_ready = 1'b0;
      tick();
      tick();
      check("reset.sum", 64'(sum0), 64'd0);
      check("reset.nmult", 64'(nm0), 64'd0);
      check("reset.valid", 64'(vld0), 64'd0);
      check("reset.ready", 64'(rdy0), 64'd1);

      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = d4[i]; in_op = o4[i];
         tick();
         check("batch.valid_timing", 64'(vld0), 64'(i == 3));
      end
      check("batch.sum", 64'(sum0), 64'd26);
      check("batch.nmult", 64'(nm0), 64'd2);
      check("batch.ovf", 64'(ovf0), 64'd0);
      check("batch.ready", 64'(rdy0), 64'd0);

      in_data = 16'd77; in_op = 1'b1;
      repeat (5) begin
         tick();
         check("hold.sum", 64'(sum0), 64'd26);
         check("hold.valid", 64'(vld0), 64'd1);
      end
      out_ready = 1'b1; in_valid = 1'b0;
      tick();
      check("release.valid", 64'(vld0), 64'd0);
      check("release.ready", 64'(rdy0), 64'd1);
      check("release.sum", 64'(sum0), 64'd0);
      out_ready = 1'b0;

      rst_n = 1'b0; tick(); rst_n = 1'b1;
      in_valid = 1'b1; in_op = 1'b0; in_data = 16'hFFFF; tick();
      in_data = 16'h0002; tick();
      in_valid = 1'b0;
`ifdef ULA_ACC_SAT_EN
      check("ovf.sum", 64'(sum1), 64'h0000_FFFF);
`else
      check("ovf.sum", 64'(sum1), 64'h0000_0001);
`endif
      check("ovf.flag", 64'(ovf1), 64'd1);
      check("ovf.valid", 64'(vld1), 64'd1);

      rst_n = 1'b0; tick(); rst_n = 1'b1;
      in_valid = 1'b1; in_data = 16'd7; tick();
      in_data = 16'd8; tick();
      clr = 1'b1; in_data = 16'd9; tick();
      clr = 1'b0;
      check("clr.sum", 64'(sum0), 64'd0);
      check("clr.ready", 64'(rdy0), 64'd1);
      check("clr.valid", 64'(vld0), 64'd0);
      in_data = 16'd1;
      repeat (4) tick();
      check("fresh.sum", 64'(sum0), 64'd4);
      check("fresh.valid", 64'(vld0), 64'd1);

      out_ready = 1'b1; in_valid = 1'b0; rst_n = 1'b0;
      tick();
      check("rst_hold.valid", 64'(vld0), 64'd0);
      check("rst_hold.sum", 64'(sum0), 64'd0);
      check("rst_hold.ready", 64'(rdy0), 64'd1);

      rst_n = 1'b1; out_ready = 1'b0;
      in_valid = 1'b1; in_data = 16'd6; in_op = 1'b1;
      tick();
      check("n1.valid", 64'(vld2), 64'd1);
      check("n1.sum", 64'(sum2), 64'd6);
      check("n1.nmult", 64'(nm2), 64'd1);
      out_ready = 1'b1;
      repeat (6) tick();

      for (int c = 0; c < 3000; c++) begin
         rst_n     = ($urandom_range(0, 99) != 0);
         clr       = ($urandom_range(0, 39) == 0);
         in_valid  = ($urandom_range(0, 9) < 7);
         in_data   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
         in_op     = 1'($urandom);
         out_ready = 1'($urandom);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
